// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_e    : controller FSM states (RUN, MEM_WAIT)
//   REG_ADDR_W : register-file address width
//   DEF_CNT_W  : default width of the performance counters
// ---------------------------------------------------------------------------
package hazard_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous active-high reset, value -> 0
//   clr   : synchronous clear, wins over inc
//   inc   : increment by one on the next rising edge (sticks at all-ones)
//   value : current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value
);

   logic [W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (clr)
         value_d = '0;
      else if (inc && (value_q != {W{1'b1}}))
         value_d = value_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) value_q <= '0;
      else     value_q <= value_d;
   end

   assign value = value_q;

endmodule : sat_counter

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
// Pipeline hazard controller feeding the stage-register enables/clears.
// Detects load-use dependences between decode and execute, freezes the whole
// pipe while a multi-cycle data-memory load completes, flushes fetch/decode on
// taken branches, and keeps saturating stall/flush event counters.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rs1/rs2_decode, uses_*   : source operands of the decode instruction
//   rd/wre/mem_read_execute  : destination info of the execute instruction
//   mem_read_memory          : memory-stage instruction is a load
//   branch_taken_execute     : taken branch/jump resolved in execute
//   counters_clear           : synchronous clear of both counters
//   stall_*                  : hold PC / IF-ID / ID-EX / EX-MEM
//   flush_decode/execute     : clear IF-ID / ID-EX to a bubble
//   mem_wait_active          : FSM is in MEM_WAIT
//   stall_cycles             : cycles with stall_fetch=1 (saturating)
//   flush_events             : cycles with flush_decode=1 (saturating)
// ---------------------------------------------------------------------------
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_decode,
   input  logic [REG_ADDR_W-1:0] rs2_decode,
   input  logic                  uses_rs1_decode,
   input  logic                  uses_rs2_decode,
   input  logic [REG_ADDR_W-1:0] rd_execute,
   input  logic                  wre_execute,
   input  logic                  mem_read_execute,
   input  logic                  mem_read_memory,
   input  logic                  branch_taken_execute,
   input  logic                  counters_clear,
   output logic                  stall_fetch,
   output logic                  stall_decode,
   output logic                  stall_execute,
   output logic                  stall_memory,
   output logic                  flush_decode,
   output logic                  flush_execute,
   output logic                  mem_wait_active,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_events
);

   localparam int CNT_BITS = $clog2(MEM_LAT) + 1;
   // Single-cycle memory never freezes the pipe.
   localparam bit MULTI_CYCLE = (MEM_LAT > 1);
   // The stall-start cycle itself is the first frozen cycle, so the wait
   // state only has to cover MEM_LAT-2 more before the release cycle.
   localparam logic [CNT_BITS-1:0] CNT_START =
      CNT_BITS'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

   state_e              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   logic load_use;
   logic mem_stall_start;
   logic advancing;

   assign load_use = mem_read_execute & wre_execute &
                     ((uses_rs1_decode & (rd_execute == rs1_decode)) |
                      (uses_rs2_decode & (rd_execute == rs2_decode)));

   // In MEM_WAIT the load in memory is the one already being waited on, so
   // mem_read_memory is only looked at from RUN.
   assign mem_stall_start = (state_q == RUN) & mem_read_memory & MULTI_CYCLE;

   assign advancing = ((state_q == RUN) & ~mem_stall_start) |
                      ((state_q == MEM_WAIT) & (cnt_q == '0));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (mem_stall_start) begin
               state_d = MEM_WAIT;
               cnt_d   = CNT_START;
            end
         end
         MEM_WAIT: begin
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      stall_fetch     = 1'b0;
      stall_decode    = 1'b0;
      stall_execute   = 1'b0;
      stall_memory    = 1'b0;
      flush_decode    = 1'b0;
      flush_execute   = 1'b0;
      mem_wait_active = 1'b0;
      if (rst) begin
         // Bubbles into IF/ID and ID/EX while held in reset.
         flush_decode  = 1'b1;
         flush_execute = 1'b1;
      end else begin
         mem_wait_active = (state_q == MEM_WAIT);
         if (!advancing) begin
            // Whole pipe frozen; pending branch/load-use wait for release.
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            stall_memory  = 1'b1;
         end else if (branch_taken_execute) begin
            // Squashes the dependent instruction, so load-use is moot.
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
         end else if (load_use) begin
            // Hold fetch/decode, drop one bubble into execute.
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
         end
      end
   end

   // ---------------- performance counters ----------------
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (counters_clear),
      .inc   (stall_fetch),
      .value (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (counters_clear),
      .inc   (flush_decode),
      .value (flush_events)
   );

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

   localparam int CW = 4;

   // output vector layout: {sf, sd, se, sm, fd, fe, mwa}
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] RSTV = 7'b0000110;
   localparam logic [6:0] LU   = 7'b1100010;
   localparam logic [6:0] BR   = 7'b0000110;
   localparam logic [6:0] MS   = 7'b1111000; // stall start, still in RUN
   localparam logic [6:0] MW   = 7'b1111001; // frozen in MEM_WAIT
   localparam logic [6:0] REL  = 7'b0000001; // plain release cycle
   localparam logic [6:0] RELB = 7'b0000111; // release with held branch
   localparam logic [6:0] RELL = 7'b1100011; // release with held load-use

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, mre, wre, mrm, br, clr, u1, u2;
   logic [3:0] rs1, rs2, rd;

   logic a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_mw;
   logic b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_mw;
   logic [CW-1:0] a_stall, a_flush, b_stall, b_flush;

   hazard_control_unit #(.MEM_LAT(3), .CNT_W(CW)) dut_a (
      .clk(clk), .rst(rst),
      .rs1_decode(rs1), .rs2_decode(rs2),
      .uses_rs1_decode(u1), .uses_rs2_decode(u2),
      .rd_execute(rd), .wre_execute(wre), .mem_read_execute(mre),
      .mem_read_memory(mrm), .branch_taken_execute(br),
      .counters_clear(clr),
      .stall_fetch(a_sf), .stall_decode(a_sd), .stall_execute(a_se),
      .stall_memory(a_sm), .flush_decode(a_fd), .flush_execute(a_fe),
      .mem_wait_active(a_mw), .stall_cycles(a_stall), .flush_events(a_flush)
   );

   hazard_control_unit #(.MEM_LAT(1), .CNT_W(CW)) dut_b (
      .clk(clk), .rst(rst),
      .rs1_decode(rs1), .rs2_decode(rs2),
      .uses_rs1_decode(u1), .uses_rs2_decode(u2),
      .rd_execute(rd), .wre_execute(wre), .mem_read_execute(mre),
      .mem_read_memory(mrm), .branch_taken_execute(br),
      .counters_clear(clr),
      .stall_fetch(b_sf), .stall_decode(b_sd), .stall_execute(b_se),
      .stall_memory(b_sm), .flush_decode(b_fd), .flush_execute(b_fe),
      .mem_wait_active(b_mw), .stall_cycles(b_stall), .flush_events(b_flush)
   );

   typedef struct packed {
      logic [6:0] a;
      logic [6:0] b;
   } exp_t;

   exp_t   sb_q[$];
   int     tests = 0;
   int     fails = 0;
   int     step_no = 0;
   logic [CW-1:0] m_stall = '0;
   logic [CW-1:0] m_flush = '0;

   task automatic idle();
      rst = 1'b0; mre = 1'b0; wre = 1'b0; mrm = 1'b0; br = 1'b0; clr = 1'b0;
      u1 = 1'b0; u2 = 1'b0; rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0;
   endtask

   task automatic set_lu();
      mre = 1'b1; wre = 1'b1; rd = 4'd5; rs2 = 4'd5; u2 = 1'b1;
   endtask

   task automatic chk_cnt(input string tag, input logic [CW-1:0] obs,
                          input logic [CW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s step %0d: got %0d, want %0d", tag, step_no, obs, exp);
      end
   endtask

   // One clock cycle: expected outputs queued when inputs are applied,
   // popped and compared mid-cycle, counters compared after the edge.
   task automatic step(input logic [6:0] ea, input logic [6:0] eb);
      exp_t e;
      logic [6:0] oa, ob;
      logic       r_now, c_now;
      step_no++;
      sb_q.push_back('{a: ea, b: eb});
      @(negedge clk);
      oa = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_mw};
      ob = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_mw};
      tests++;
      assert (sb_q.size() > 0) else begin
         fails++;
         $error("FAIL scoreboard step %0d: got empty queue, want entry", step_no);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         tests++;
         assert (oa === e.a) else begin
            fails++;
            $error("FAIL outA step %0d: got %b, want %b", step_no, oa, e.a);
         end
         tests++;
         assert (ob === e.b) else begin
            fails++;
            $error("FAIL outB step %0d: got %b, want %b", step_no, ob, e.b);
         end
      end
      r_now = rst;
      c_now = clr;
      @(posedge clk);
      #1;
      if (r_now || c_now) begin
         m_stall = '0;
         m_flush = '0;
      end else begin
         if (ea[6] && m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
         if (ea[2] && m_flush != {CW{1'b1}}) m_flush = m_flush + 1'b1;
      end
      chk_cnt("stall_cycles", a_stall, m_stall);
      chk_cnt("flush_events", a_flush, m_flush);
   endtask

   initial begin
      idle();
      // reset held 3 cycles with a load in memory
      rst = 1'b1; mrm = 1'b1;
      repeat (3) step(RSTV, RSTV);
      // first cycle out of reset evaluates in RUN: memory stall starts
      rst = 1'b0;
      step(MS, NONE);
      step(MW, NONE);
      step(REL, NONE);          // load still flagged, ignored at release
      idle();
      step(NONE, NONE);
      chk_cnt("memstall_total", a_stall, 4'd2);

      // load-use
      clr = 1'b1; step(NONE, NONE); idle();
      set_lu();
      step(LU, LU);
      chk_cnt("loaduse_total", a_stall, 4'd1);
      u2 = 1'b0; step(NONE, NONE);                   // operand not read
      idle(); mre = 1'b1; wre = 1'b1; rd = 4'd5; rs1 = 4'd6; u1 = 1'b1;
      step(NONE, NONE);                              // different register
      rs1 = 4'd5; step(LU, LU);                      // rs1 match
      wre = 1'b0; step(NONE, NONE);                  // load not writing

      // branch beats load-use
      idle(); set_lu(); br = 1'b1;
      step(BR, BR);
      idle(); clr = 1'b1; step(NONE, NONE); idle();

      // branch arriving during a memory stall
      mrm = 1'b1; br = 1'b1;
      step(MS, BR);
      step(MW, BR);
      step(RELB, BR);
      idle();
      step(NONE, NONE);
      chk_cnt("branch_after_wait", a_flush, 4'd1);

      // load-use held frozen, acted on at release
      mrm = 1'b1; set_lu();
      step(MS, LU);
      step(MW, LU);
      step(RELL, LU);
      idle(); step(NONE, NONE);

      // reset in the middle of a wait
      mrm = 1'b1; step(MS, NONE);
      rst = 1'b1; step(RSTV, RSTV);
      idle(); step(NONE, NONE);

      // saturation and clear priority
      clr = 1'b1; step(NONE, NONE); idle();
      set_lu();
      repeat (20) step(LU, LU);
      chk_cnt("saturate", a_stall, 4'd15);
      clr = 1'b1;
      step(LU, LU);
      chk_cnt("clear_prio", a_stall, 4'd0);
      idle(); step(NONE, NONE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish, want finish before 50000");
      $fatal(1, "timeout");
   end

endmodule : tb_hazard_control_unit
